// File: rtl/apb_slave_regbank.sv
// APB completer holding a bank of 2^ADDR_WIDTH registers; the top address is a
// read-only ID register. Programmable wait states, error response on ID writes.
module apb_slave_regbank #(
  parameter int                    DATA_WIDTH  = 16,
  parameter int                    ADDR_WIDTH  = 3,
  parameter int                    WAIT_STATES = 0,
  parameter logic [DATA_WIDTH-1:0] ID_VALUE    = 16'hA5B0
) (
  input  logic                  Pclk,
  input  logic                  Presetn,
  input  logic                  Psel,
  input  logic                  Penable,
  input  logic                  Pwrite,
  input  logic [ADDR_WIDTH-1:0] Paddr,
  input  logic [DATA_WIDTH-1:0] Pwdata,
  output logic [DATA_WIDTH-1:0] Prdata,
  output logic                  Pready,
  output logic                  Pslverr
);

  localparam int                    NREG     = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] TOP_ADDR = '1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_READY} state_t;

  state_t                r_state, w_state_nxt;
  logic [3:0]            r_cnt, w_cnt_nxt;
  logic                  w_enter_ready;
  logic                  w_complete;
  logic                  w_is_top;
  logic [DATA_WIDTH-1:0] w_rd_data;
  logic [DATA_WIDTH-1:0] r_regs [NREG];
  logic [DATA_WIDTH-1:0] r_prdata;
  logic                  r_pready;
  logic                  r_pslverr;

  assign w_is_top  = (Paddr == TOP_ADDR);
  assign w_rd_data = w_is_top ? ID_VALUE : r_regs[Paddr];

  // NOTE: every output of this block gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_enter_ready = 1'b0;
    w_complete    = 1'b0;
    case (r_state)
      S_IDLE: begin
        // Access strobe without a preceding setup is ignored.
        if (Psel && !Penable) begin
          if (WAIT_STATES == 0) begin
            w_state_nxt   = S_READY;
            w_enter_ready = 1'b1;
          end else begin
            w_state_nxt = S_WAIT;
            w_cnt_nxt   = 4'(WAIT_STATES);
          end
        end
      end
      S_WAIT: begin
        if (!Psel) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
          if (r_cnt == 4'd1) begin
            w_state_nxt   = S_READY;
            w_enter_ready = 1'b1;
          end
        end
      end
      S_READY: begin
        if (!Psel) begin
          w_state_nxt = S_IDLE;
        end else if (Penable) begin
          w_state_nxt = S_IDLE;
          w_complete  = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge Pclk) begin
    if (!Presetn) begin
      r_state   <= S_IDLE;
      r_cnt     <= 4'd0;
      r_prdata  <= '0;
      r_pready  <= 1'b0;
      r_pslverr <= 1'b0;
      // NOTE: the bank is built from flops rather than a RAM macro, so it can
      // be cleared in reset; the ID slot is never written and stays unused.
      for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_enter_ready) begin
        r_pready  <= 1'b1;
        r_pslverr <= Pwrite && w_is_top;
        if (!Pwrite) r_prdata <= w_rd_data;
      end else if (w_state_nxt != S_READY) begin
        r_pready  <= 1'b0;
        r_pslverr <= 1'b0;
      end
      if (w_complete && Pwrite && !w_is_top) r_regs[Paddr] <= Pwdata;
    end
  end

  assign Prdata  = r_prdata;
  assign Pready  = r_pready;
  assign Pslverr = r_pslverr;

endmodule

// File: tb/tb_apb_slave_regbank.sv
// Bench for apb_slave_regbank: two instances (0 and 3 wait states) driven by an
// APB master task; a monitor pops expected responses from per-instance queues.
module tb_apb_slave_regbank;

  localparam int          DW  = 16;
  localparam int          AW  = 3;
  localparam logic [15:0] ID  = 16'hA5B0;
  localparam int          WS0 = 0;
  localparam int          WS1 = 3;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [1:0]        psel, penable, pwrite;
  logic [AW-1:0]     paddr  [2];
  logic [DW-1:0]     pwdata [2];
  logic [DW-1:0]     prdata [2];
  logic [1:0]        pready, pslverr;

  always #5 clk = ~clk;

  apb_slave_regbank #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WAIT_STATES(WS0), .ID_VALUE(ID)) u_dut0 (
    .Pclk(clk), .Presetn(rst_n), .Psel(psel[0]), .Penable(penable[0]), .Pwrite(pwrite[0]),
    .Paddr(paddr[0]), .Pwdata(pwdata[0]), .Prdata(prdata[0]), .Pready(pready[0]), .Pslverr(pslverr[0])
  );

  apb_slave_regbank #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WAIT_STATES(WS1), .ID_VALUE(ID)) u_dut1 (
    .Pclk(clk), .Presetn(rst_n), .Psel(psel[1]), .Penable(penable[1]), .Pwrite(pwrite[1]),
    .Paddr(paddr[1]), .Pwdata(pwdata[1]), .Prdata(prdata[1]), .Pready(pready[1]), .Pslverr(pslverr[1])
  );

  typedef struct {
    logic [DW-1:0] data;
    logic          err;
  } exp_t;

  exp_t          q0[$], q1[$];
  logic [DW-1:0] mem     [2][8];
  logic [DW-1:0] last_rd [2];
  int            total = 0;
  int            bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int ws(input int k);
    return (k == 0) ? WS0 : WS1;
  endfunction

  // Reference model: a reset clears the whole bank and the read-data holding value.
  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      last_rd[k] = '0;
      for (int a = 0; a < 8; a++) mem[k][a] = '0;
    end
  endtask

  // Full transfer on instance k; caller must be just after a rising edge.
  task automatic xfer(input int k, input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] data);
    exp_t e;
    int   n;
    if (wr) begin
      e.err  = (addr == 3'd7);
      e.data = last_rd[k];
      if (addr != 3'd7) mem[k][addr] = data;
    end else begin
      e.err      = 1'b0;
      e.data     = (addr == 3'd7) ? ID : mem[k][addr];
      last_rd[k] = e.data;
    end
    if (k == 0) q0.push_back(e); else q1.push_back(e);
    psel[k] = 1'b1; penable[k] = 1'b0; pwrite[k] = wr; paddr[k] = addr; pwdata[k] = data;
    @(posedge clk); #1;
    penable[k] = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (pready[k]) break;
      n++;
      if (n > 40) begin
        check("pready_timeout", 32'd0, 32'd1);
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    psel[k] = 1'b0; penable[k] = 1'b0;
  endtask

  task automatic complete(input int k, input int waits);
    exp_t e;
    if ((k == 0 && q0.size() == 0) || (k == 1 && q1.size() == 0)) begin
      check("unexpected_completion", 32'(k), 32'hFFFF_FFFF);
      return;
    end
    e = (k == 0) ? q0.pop_front() : q1.pop_front();
    check($sformatf("prdata_dut%0d", k), 32'(prdata[k]), 32'(e.data));
    check($sformatf("pslverr_dut%0d", k), 32'(pslverr[k]), 32'(e.err));
    check($sformatf("wait_cycles_dut%0d", k), 32'(waits), 32'(ws(k)));
  endtask

  // Monitor: counts low-Pready access cycles and checks each completion.
  initial begin
    int wcnt[2];
    wcnt[0] = 0; wcnt[1] = 0;
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        if (rst_n !== 1'b1 || !psel[k]) wcnt[k] = 0;
        else if (penable[k]) begin
          if (!pready[k]) wcnt[k]++;
          else begin
            complete(k, wcnt[k]);
            wcnt[k] = 0;
          end
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    psel = '0; penable = '0; pwrite = '0;
    for (int k = 0; k < 2; k++) begin paddr[k] = '0; pwdata[k] = '0; end
    model_reset();

    // Reset with slave select held high.
    rst_n = 1'b0; psel = 2'b11;
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      check("rst_pready", 32'(pready[k]), 32'd0);
      check("rst_pslverr", 32'(pslverr[k]), 32'd0);
      check("rst_prdata", 32'(prdata[k]), 32'd0);
    end
    psel = 2'b00;
    rst_n = 1'b1;
    @(posedge clk); #1;
    xfer(0, 1'b0, 3'd3, 16'h0);
    xfer(1, 1'b0, 3'd3, 16'h0);

    // Zero-wait write/read, wait-state ID read, illegal ID write.
    xfer(0, 1'b1, 3'd2, 16'h1234);
    xfer(0, 1'b0, 3'd2, 16'h0);
    xfer(1, 1'b0, 3'd7, 16'h0);
    xfer(1, 1'b1, 3'd7, 16'hFFFF);
    xfer(1, 1'b0, 3'd7, 16'h0);
    xfer(0, 1'b1, 3'd7, 16'hFFFF);
    xfer(0, 1'b0, 3'd7, 16'h0);

    // Abort a write during wait states: no completion, no write.
    psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1; paddr[1] = 3'd1; pwdata[1] = 16'hBEEF;
    @(posedge clk); #1;
    penable[1] = 1'b1;
    @(posedge clk); #1;
    psel[1] = 1'b0; penable[1] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("abort_pready", 32'(pready[1]), 32'd0);
    end
    @(posedge clk); #1;
    xfer(1, 1'b0, 3'd1, 16'h0);

    // Back-to-back write then read, then reset in the middle of a read.
    xfer(0, 1'b1, 3'd0, 16'h0001);
    xfer(0, 1'b0, 3'd0, 16'h0);
    xfer(1, 1'b1, 3'd0, 16'h0001);
    xfer(1, 1'b0, 3'd0, 16'h0);
    psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b0; paddr[1] = 3'd0;
    @(posedge clk); #1;
    penable[1] = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("midrst_pready", 32'(pready[1]), 32'd0);
    check("midrst_prdata", 32'(prdata[1]), 32'd0);
    check("midrst_prdata_dut0", 32'(prdata[0]), 32'd0);
    psel = 2'b00; penable = 2'b00;
    rst_n = 1'b1;
    model_reset();
    @(posedge clk); #1;
    xfer(1, 1'b0, 3'd0, 16'h0);
    xfer(0, 1'b0, 3'd0, 16'h0);
    xfer(0, 1'b0, 3'd2, 16'h0);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 80; i++) begin
      int            k;
      logic          wr;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      k  = int'($urandom_range(0, 1));
      wr = 1'($urandom_range(0, 1));
      a  = AW'($urandom_range(0, 7));
      d  = DW'($urandom);
      xfer(k, wr, a, d);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
    end

    repeat (3) @(posedge clk);
    check("queue0_drained", 32'(q0.size()), 32'd0);
    check("queue1_drained", 32'(q1.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
